mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Unified instruction/data memory slave answering the multicycle processor's memory requests (instruction fetch and load/store) with a request/ready handshake.
- Sits between the control unit / datapath and the word-organised storage.
- Inserts a configurable number of wait states, so the control FSM must stall its fetch and memory states until ready.
- Supports word reads and byte-enabled writes, and flags misaligned accesses.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width (fixed multiple of 8).
- DEPTH, 64, number of words stored (power of two).
- WAIT_CYCLES, 2, wait states between request capture and ready (0 allowed).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- REQ  in  1  request valid; sampled only in IDLE.
- WE  in  1  1 = write, 0 = read; sampled with REQ.
- BE  in  DATA_W/8  byte enables for writes; ignored on reads.
- ADDR  in  ADDR_W  byte address.
- WDATA  in  DATA_W  write data.
- RDATA  out  DATA_W  read data; valid only while RDY=1.
- RDY  out  1  one-cycle completion pulse.
- BUSY  out  1  request in flight.
- ERR  out  1  misaligned access; qualified by RDY.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE; wait counter = 0.
  - RDY, BUSY and ERR = 0; RDATA = 0.
  - Storage array is not cleared.
  - An in-flight write that has not reached RESP is dropped.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On REQ=1, capture WE, BE, ADDR and WDATA into holding registers, then set BUSY=1.
  - Go to WAIT when WAIT_CYCLES>0, else go straight to RESP.
  - REQ=0: remain in IDLE.
- WAIT:
  - Counter increments each cycle.
  - When counter = WAIT_CYCLES-1, go to RESP.
  - Inputs are ignored; REQ asserted here is dropped, not queued.
- RESP (one cycle):
  - RDY=1.
  - ERR=1 if captured ADDR[1:0] != 0.
  - Read: RDATA = mem[captured ADDR[log2(DEPTH)+1:2]].
  - Write: enabled bytes are updated at the end of this cycle; RDATA = 0.
  - Misaligned access: no write occurs and RDATA = 0.
  - Next state is IDLE; BUSY drops with the return to IDLE.
- Latency: REQ accepted in cycle N gives RDY in cycle N+1+WAIT_CYCLES.
- Throughput: at most one access per WAIT_CYCLES+2 cycles. REQ held high through RESP is re-accepted in the IDLE cycle that follows.
- Address range: index uses only ADDR[log2(DEPTH)+1:2]. Upper bits are ignored, so out-of-range addresses wrap modulo DEPTH words with no error.
- Write then read of the same word: the read observes the new data, because the write commits before the next capture.
- BE=0 on a write: handshake completes normally and memory is unchanged.
- Outputs RDY, ERR and RDATA are registered; BUSY is decoded from state (IDLE → 0).
- Memory init: optional initialisation from hex file through a simulation-only initial block; not part of the reset behaviour.

Decomposition:
- Shared package: state encoding constants (IDLE=0, WAIT=1, RESP=2) and the word-index width function (clog2).
- One natural sub-module, mem_array: synchronous-write, asynchronous-read word array with byte-enable write. The responder FSM instantiates it.

Test Plan:
- WAIT_CYCLES=2: write WDATA=32'hDEADBEEF, ADDR=8, BE=4'hF at cycle 0. Required: RDY in cycle 3, ERR=0, BUSY=1 in cycles 1-3. A following read of ADDR=8 returns RDATA=32'hDEADBEEF with RDY.
- Partial write: mem[2]=32'h11223344, then write BE=4'b0010, WDATA=32'h0000AA00, ADDR=8. Required: a read returns 32'h1122AA44.
- Misaligned: write at ADDR=6. Required: RDY with ERR=1 and memory unchanged. A read at ADDR=6 returns RDATA=0 and ERR=1.
- Wrap: DEPTH=64, write 32'h5 at ADDR=32'h100. Required: a read at ADDR=0 returns 32'h5.
- REQ pulsed during WAIT: the request is ignored and only one RDY pulse occurs. WAIT_CYCLES=0: RDY arrives in cycle N+1.
- RST asserted mid-WAIT of a write to ADDR=4. Required: RDY, BUSY and ERR drop immediately (asynchronously), no RDY pulse follows, and a later read of ADDR=4 shows the old contents.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the unified instruction/data memory responder:
//   - state_e   : responder FSM state encoding (IDLE=0, WAIT=1, RESP=2)
//   - BYTE_W    : width of one byte lane
//   - idx_width : number of word-index bits needed for a given depth
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int BYTE_W = 8;

    // Word-index width; a single-word array still needs one index bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Word-organised storage with a synchronous byte-enabled write port and an
// asynchronous read port. Contents are never reset.
//
// Ports:
//   clk_i    in   clock, rising edge
//   we_i     in   write strobe (qualified per lane by be_i)
//   be_i     in   byte enables
//   waddr_i  in   write word index
//   wdata_i  in   write data
//   raddr_i  in   read word index
//   rdata_o  out  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module mem_array
    import mem_responder_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int IDX_W  = idx_width(DEPTH),
    localparam int NB     = DATA_W / BYTE_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [NB-1:0]     be_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // One independent array per byte lane keeps each lane's write a plain
    // whole-element store.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [BYTE_W-1:0] lane_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (we_i && be_i[gi]) begin
                lane_q[waddr_i] <= wdata_i[gi*BYTE_W +: BYTE_W];
            end
        end

        assign rdata_o[gi*BYTE_W +: BYTE_W] = lane_q[raddr_i];
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory slave for the multicycle processor. A request is captured in IDLE,
// held for WAIT_CYCLES wait states, then answered with a one-cycle RESP
// (rdy_o pulse). Reads return a whole word, writes are byte-enabled, and
// accesses whose low address bits are non-zero are flagged and suppressed.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset
//   req_i    in   request valid, only sampled in IDLE
//   we_i     in   1 = write, 0 = read
//   be_i     in   byte enables (writes only)
//   addr_i   in   byte address (only the word-index bits are used)
//   wdata_i  in   write data
//   rdata_o  out  read data, valid while rdy_o = 1
//   rdy_o    out  one-cycle completion pulse
//   busy_o   out  request in flight
//   err_o    out  misaligned access, qualified by rdy_o
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [DATA_W/BYTE_W-1:0] be_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     rdy_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int NB        = DATA_W / BYTE_W;
    localparam int IDX_W     = idx_width(DEPTH);
    localparam int CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    // Holding registers for the accepted request. Only the index and
    // alignment bits of the address are kept; the rest wrap away.
    logic               we_q,    we_d;
    logic [NB-1:0]      be_q,    be_d;
    logic [IDX_W+1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    logic               rdy_q,   rdy_d;
    logic               err_q,   err_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               mem_we;
    logic [DATA_W-1:0]  mem_rdata;
    logic               misaligned;

    logic               unused_addr_hi;
    assign unused_addr_hi = ^addr_i[ADDR_W-1:IDX_W+2];

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    be_d    = be_i;
                    addr_d  = addr_i[IDX_W+1:0];
                    wdata_d = wdata_i;
                    cnt_d   = '0;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(WAIT_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // The response is computed on the edge that enters RESP so that rdy, err
    // and rdata come straight from registers during RESP. Using the *_d
    // holding values covers the zero-wait case, where capture and entry to
    // RESP share one edge. Any write from the previous RESP has already
    // committed by then, so a following read sees it.
    always_comb begin
        misaligned = (addr_d[1:0] != 2'b00);
        rdy_d      = (state_d == ST_RESP);
        err_d      = (state_d == ST_RESP) && misaligned;
        rdata_d    = '0;
        if ((state_d == ST_RESP) && !we_d && !misaligned) begin
            rdata_d = mem_rdata;
        end
        // Writes commit at the end of RESP; misaligned writes are dropped.
        mem_we = (state_q == ST_RESP) && we_q && (addr_q[1:0] == 2'b00);
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign rdy_o   = rdy_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .be_i    (be_q),
        .waddr_i (addr_q[IDX_W+1:2]),
        .wdata_i (wdata_q),
        .raddr_i (addr_d[IDX_W+1:2]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req0 = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] rdata, rdata0;
    logic        rdy, busy, err;
    logic        rdy0, busy0, err0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .rdy_o(rdy),
        .busy_o(busy), .err_o(err)
    );

    mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata0), .rdy_o(rdy0),
        .busy_o(busy0), .err_o(err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a word array plus one outstanding request
    // with the cycle it was accepted and the cycle its response is due.
    // ------------------------------------------------------------------
    logic [31:0] mem_m [DEPTH];
    bit          infl = 0;
    int          acc_c = 0;
    int          resp_c = 0;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;

    always @(negedge clk) begin : compare_p
        logic [31:0] e_rdata;
        logic        e_err, e_rdy, e_busy;
        bit          can_accept;
        int          idx;
        if (rst) begin
            chk("rst_rdy", {31'b0, rdy}, 32'd0);
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_err", {31'b0, err}, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            infl = 0;
        end else begin
            e_rdy  = infl && (cyc == resp_c);
            e_busy = infl && (cyc > acc_c);
            chk("rdy", {31'b0, rdy}, {31'b0, e_rdy});
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            can_accept = !infl;
            if (e_rdy) begin
                idx     = (m_addr / 4) % DEPTH;
                e_err   = (m_addr % 4) != 0;
                e_rdata = (!m_we && !e_err) ? mem_m[idx] : 32'h0;
                chk("err", {31'b0, err}, {31'b0, e_err});
                chk("rdata", rdata, e_rdata);
                if (m_we && !e_err) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_be[b]) mem_m[idx][b*8 +: 8] = m_wdata[b*8 +: 8];
                    end
                end
                infl = 0;
            end
            if (can_accept && req) begin
                infl    = 1;
                acc_c   = cyc;
                resp_c  = cyc + 1 + W;
                m_we    = we;
                m_be    = be;
                m_addr  = addr;
                m_wdata = wdata;
            end
        end
    end

    // One request, wait (bounded) for its response; returns in the IDLE
    // cycle after RESP. lat is counted from the accepting cycle.
    task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic er, output int lat);
        int start;
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        start = cyc;
        @(posedge clk); #1;
        req = 1'b0;
        lat = -1; rd = 32'h0; er = 1'b0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            if (rdy) begin
                lat = cyc - start;
                rd  = rdata;
                er  = err;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for rdy addr=%h", a);
        end
        $display("txn we=%0d be=%h addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 w, b, a, d, rd, er, lat);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          pulses;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy", {31'b0, rdy}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic write then read
        access(1'b1, 4'hF, 32'h8, 32'hDEADBEEF, rd, er, lat);
        chk("wr_lat", lat, 32'd3);
        chk("wr_err", {31'b0, er}, 32'd0);
        access(1'b0, 4'h0, 32'h8, 32'h0, rd, er, lat);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_lat", lat, 32'd3);

        // Partial write
        access(1'b1, 4'hF, 32'h8, 32'h11223344, rd, er, lat);
        access(1'b1, 4'b0010, 32'h8, 32'h0000AA00, rd, er, lat);
        access(1'b0, 4'h0, 32'h8, 32'h0, rd, er, lat);
        chk("partial", rd, 32'h1122AA44);

        // Misaligned
        access(1'b1, 4'hF, 32'h4, 32'hCAFEF00D, rd, er, lat);
        access(1'b1, 4'hF, 32'h6, 32'hFFFFFFFF, rd, er, lat);
        chk("mis_wr_err", {31'b0, er}, 32'd1);
        access(1'b0, 4'h0, 32'h4, 32'h0, rd, er, lat);
        chk("mis_unchanged", rd, 32'hCAFEF00D);
        access(1'b0, 4'h0, 32'h6, 32'h0, rd, er, lat);
        chk("mis_rd_data", rd, 32'h0);
        chk("mis_rd_err", {31'b0, er}, 32'd1);

        // Wrap
        access(1'b1, 4'hF, 32'h100, 32'h5, rd, er, lat);
        access(1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat);
        chk("wrap", rd, 32'h5);

        // BE = 0 write leaves memory alone
        access(1'b1, 4'h0, 32'h0, 32'hFFFFFFFF, rd, er, lat);
        chk("be0_lat", lat, 32'd3);
        access(1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat);
        chk("be0_data", rd, 32'h5);

        // REQ pulsed again during WAIT is dropped
        req = 1'b1; we = 1'b0; addr = 32'h8; pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (rdy) pulses++;
            if (i == 1) req = 1'b0;
            if (i == 2) req = 1'b1;
            if (i == 3) req = 1'b0;
        end
        chk("wait_req_pulses", pulses, 32'd1);
        $display("txn pulse-during-wait rdy_pulses=%0d", pulses);

        // REQ held through RESP is re-accepted in the following IDLE
        req = 1'b1; we = 1'b0; addr = 32'h8; pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (rdy) pulses++;
            if (i == 5) req = 1'b0;
        end
        chk("b2b_pulses", pulses, 32'd2);
        $display("txn back-to-back rdy_pulses=%0d", pulses);

        // Zero wait states: RDY in cycle N+1
        we = 1'b1; be = 4'hF; addr = 32'hC; wdata = 32'h0BADCAFE; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        chk("w0_wr_rdy", {31'b0, rdy0}, 32'd1);
        chk("w0_wr_busy", {31'b0, busy0}, 32'd1);
        chk("w0_wr_err", {31'b0, err0}, 32'd0);
        @(posedge clk); #1;
        chk("w0_idle_rdy", {31'b0, rdy0}, 32'd0);
        chk("w0_idle_busy", {31'b0, busy0}, 32'd0);
        we = 1'b0; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        chk("w0_rd_rdy", {31'b0, rdy0}, 32'd1);
        chk("w0_rd_data", rdata0, 32'h0BADCAFE);
        $display("txn w0 read addr=0000000c rdata=%h", rdata0);
        @(posedge clk); #1;

        // Reset in the middle of a write's WAIT
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h4; wdata = 32'h12345678;
        @(posedge clk); #1;
        req = 1'b0;
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_rdy", {31'b0, rdy}, 32'd0);
        chk("async_rst_err", {31'b0, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy) pulses++;
        end
        chk("rst_no_rdy", pulses, 32'd0);
        $display("txn reset-mid-wait rdy_pulses=%0d", pulses);
        access(1'b0, 4'h0, 32'h4, 32'h0, rd, er, lat);
        chk("rst_old_data", rd, 32'hCAFEF00D);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
